// File: rtl/operand_fetch.sv
// operand_fetch
//   Read-side companion to the register bank. Accepts one decoded ALU
//   instruction, waits in CHECK while either source has a pending ALU
//   writeback, then samples both operands from the bank outputs and presents
//   them to the ALU over a valid/ready handshake. A 4-bit busy scoreboard
//   tracks destinations of issued operations by snooping the bank writeback.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   o1..o4              : bank register contents, registers 0..3
//   write, out_sel      : bank writeback strobe and index (snooped)
//   instr_valid/ready   : decoder handshake
//   src_a, src_b, dst   : source / destination register indices
//   opcode              : ALU operation code
//   op_valid/ready      : ALU handshake
//   op_a, op_b          : captured operand values
//   op_code, op_dst     : captured opcode and destination
//   busy                : bit i set = register i has a pending writeback
//   stall_cnt           : saturating count of hazard-stall cycles
module operand_fetch #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] o1,
  input  logic [DATA_W-1:0] o2,
  input  logic [DATA_W-1:0] o3,
  input  logic [DATA_W-1:0] o4,
  input  logic              write,
  input  logic [1:0]        out_sel,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        src_a,
  input  logic [1:0]        src_b,
  input  logic [1:0]        dst,
  input  logic [2:0]        opcode,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [2:0]        op_code,
  output logic [1:0]        op_dst,
  output logic [3:0]        busy,
  output logic [7:0]        stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ISSUE
  } state_t;

  state_t            state;
  logic [1:0]        cap_a;
  logic [1:0]        cap_b;
  logic [1:0]        cap_dst;
  logic [2:0]        cap_op;
  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_b;
  logic              hazard;
  logic              handshake;
  logic [3:0]        busy_next;

  always_comb begin
    val_a = o1;
    case (cap_a)
      2'd0:    val_a = o1;
      2'd1:    val_a = o2;
      2'd2:    val_a = o3;
      default: val_a = o4;
    endcase
  end

  always_comb begin
    val_b = o1;
    case (cap_b)
      2'd0:    val_b = o1;
      2'd1:    val_b = o2;
      2'd2:    val_b = o3;
      default: val_b = o4;
    endcase
  end

  assign hazard    = busy[cap_a] | busy[cap_b];
  assign handshake = (state == ISSUE) && op_valid && op_ready;

  // Writeback clear is applied first so a same-index set at the same edge wins.
  always_comb begin
    busy_next = busy;
    if (write) busy_next[out_sel] = 1'b0;
    if (handshake) busy_next[op_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instr_ready <= 1'b0;
      op_valid    <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op_code     <= '0;
      op_dst      <= '0;
      busy        <= '0;
      stall_cnt   <= '0;
      cap_a       <= '0;
      cap_b       <= '0;
      cap_dst     <= '0;
      cap_op      <= '0;
    end else begin
      busy <= busy_next;
      case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            cap_a       <= src_a;
            cap_b       <= src_b;
            cap_dst     <= dst;
            cap_op      <= opcode;
            instr_ready <= 1'b0;
            state       <= CHECK;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        CHECK: begin
          if (hazard) begin
            if (stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
          end else begin
            op_a     <= val_a;
            op_b     <= val_b;
            op_code  <= cap_op;
            op_dst   <= cap_dst;
            op_valid <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (handshake) begin
            op_valid    <= 1'b0;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          op_valid    <= 1'b0;
          instr_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed testbench for operand_fetch. Inputs are driven and outputs sampled
// 1 time unit after each rising edge.
module tb_operand_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] o1, o2, o3, o4;
  logic       write;
  logic [1:0] out_sel;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] src_a, src_b, dst;
  logic [2:0] opcode;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] op_a, op_b;
  logic [2:0] op_code;
  logic [1:0] op_dst;
  logic [3:0] busy;
  logic [7:0] stall_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  operand_fetch #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .o1(o1), .o2(o2), .o3(o3), .o4(o4),
    .write(write), .out_sel(out_sel),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .src_a(src_a), .src_b(src_b), .dst(dst), .opcode(opcode),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_code(op_code), .op_dst(op_dst),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bank(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    o1 = a; o2 = b; o3 = c; o4 = d;
  endtask

  // Present an instruction for exactly one edge (the accept edge).
  task automatic accept(input logic [1:0] sa, input logic [1:0] sb,
                        input logic [1:0] d, input logic [2:0] opc);
    instr_valid = 1'b1; src_a = sa; src_b = sb; dst = d; opcode = opc;
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    set_bank(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    write = 1'($urandom); out_sel = 2'($urandom);
    instr_valid = 1'($urandom); src_a = 2'($urandom); src_b = 2'($urandom);
    dst = 2'($urandom); opcode = 3'($urandom); op_ready = 1'($urandom);
    tick();
    tick();
    check("rst_op_valid", op_valid, 0);
    check("rst_instr_ready", instr_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_op_code", op_code, 0);
    check("rst_op_dst", op_dst, 0);
    rst = 1'b0; instr_valid = 1'b0; write = 1'b0; op_ready = 1'b1;
    tick();
    check("post_rst_ready", instr_ready, 1);

    // Basic issue
    set_bank(8'h11, 8'h22, 8'h33, 8'h44);
    accept(2'd2, 2'd0, 2'd1, 3'd5);
    check("basic_ready_low", instr_ready, 0);
    check("basic_check_valid", op_valid, 0);
    tick();
    check("basic_valid", op_valid, 1);
    check("basic_op_a", op_a, 8'h33);
    check("basic_op_b", op_b, 8'h11);
    check("basic_op_code", op_code, 5);
    check("basic_op_dst", op_dst, 1);
    tick();
    check("basic_hs_valid", op_valid, 0);
    check("basic_busy", busy, 4'b0010);
    check("basic_hs_ready", instr_ready, 1);

    // RAW hazard on register 1
    accept(2'd1, 2'd3, 2'd2, 3'd2);
    op_ready = 1'b0;
    tick();
    check("raw_stall1", stall_cnt, 1);
    check("raw_stall_valid", op_valid, 0);
    tick();
    check("raw_stall2", stall_cnt, 2);
    write = 1'b1; out_sel = 2'd1; o2 = 8'h5A;
    tick();
    write = 1'b0;
    check("raw_wb_busy", busy, 0);
    check("raw_wb_stall", stall_cnt, 3);
    tick();
    check("raw_valid", op_valid, 1);
    check("raw_op_a", op_a, 8'h5A);
    check("raw_op_b", op_b, 8'h44);

    // Backpressure: bundle held while bank changes
    for (int i = 0; i < 5; i++) begin
      set_bank(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      tick();
      check("bp_valid", op_valid, 1);
      check("bp_op_a", op_a, 8'h5A);
      check("bp_op_b", op_b, 8'h44);
      check("bp_op_code", op_code, 2);
      check("bp_op_dst", op_dst, 2);
    end
    op_ready = 1'b1;
    tick();
    check("bp_hs_valid", op_valid, 0);
    check("bp_hs_ready", instr_ready, 1);
    check("bp_busy", busy, 4'b0100);

    // Same-register sources; handshake for dst=3 with writeback to 3
    set_bank(8'h11, 8'h22, 8'h33, 8'h44);
    accept(2'd0, 2'd0, 2'd3, 3'd7);
    tick();
    check("same_op_a", op_a, 8'h11);
    check("same_op_b", op_b, 8'h11);
    write = 1'b1; out_sel = 2'd3;
    tick();
    write = 1'b0;
    check("setclr_busy", busy, 4'b1100);

    // Saturation: hazard on register 3 held for 300 cycles
    op_ready = 1'b0;
    accept(2'd3, 2'd0, 2'd1, 3'd1);
    tick();
    check("sat_first", stall_cnt, 4);
    for (int i = 0; i < 300; i++) tick();
    check("sat_cnt", stall_cnt, 255);
    check("sat_valid", op_valid, 0);
    write = 1'b1; out_sel = 2'd3;
    tick();
    write = 1'b0;
    check("sat_hold", stall_cnt, 255);
    tick();
    check("sat_exit_valid", op_valid, 1);
    check("sat_op_a", op_a, 8'h44);
    // Clear of 2 and set of 1 on the same edge
    op_ready = 1'b1; write = 1'b1; out_sel = 2'd2;
    tick();
    write = 1'b0;
    check("diff_busy", busy, 4'b0010);

    // Build busy=1010 then reset while in ISSUE
    accept(2'd0, 2'd0, 2'd3, 3'd0);
    tick();
    tick();
    check("pre_busy", busy, 4'b1010);
    op_ready = 1'b0;
    accept(2'd0, 2'd2, 2'd0, 3'd4);
    tick();
    check("mid_valid", op_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", op_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_stall", stall_cnt, 0);
    tick();
    check("mid_rst_ready", instr_ready, 1);
    op_ready = 1'b1;
    accept(2'd1, 2'd2, 2'd0, 3'd3);
    tick();
    check("after_op_a", op_a, 8'h22);
    check("after_op_b", op_b, 8'h33);
    check("after_op_code", op_code, 3);
    tick();
    check("after_busy", busy, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
